// File: rtl/cycle_display_pkg.sv
// Shared constants for the cycle_display performance counters.
// CNT_W_DEF is the default counter width; CNT_ALL_ONES is the saturation ceiling.
package cycle_display_pkg;

  localparam int CNT_W_DEF = 32;

  // Widest counter supported; narrower counters take the low bits.
  localparam int CNT_W_MAX = 64;

  localparam logic [CNT_W_MAX-1:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/cycle_display_event_counter.sv
// One registered event counter: counts edges where en && inc.
// Ports: clk, rst (sync, active-high), en, inc -> count [W-1:0].
// Wraps at all-ones; saturates instead when CYCLE_DISPLAY_SAT_EN is defined.
module event_counter
  import cycle_display_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

`ifdef CYCLE_DISPLAY_SAT_EN
  localparam logic [W-1:0] MAX = CNT_ALL_ONES[W-1:0];
`endif

  always_comb begin
    count_d = count_q;
    if (en && inc) begin
`ifdef CYCLE_DISPLAY_SAT_EN
      if (count_q != MAX) begin
        count_d = count_q + W'(1);
      end
`else
      count_d = count_q + W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cycle_display.sv
// Pipeline performance counters: executed cycles, jumps, taken branches, load-use stalls.
// Ports: clk, rst (sync, active-high), stop, jmp, bjmp, dependency ->
//   total_cycle, num_uncontrol, num_control, num_loaduse [CNT_W-1:0], all registered.
// Build option: CYCLE_DISPLAY_SAT_EN makes counters saturate instead of wrap.
module cycle_display
  import cycle_display_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic             jmp,
  input  logic             bjmp,
  input  logic             dependency,
  output logic [CNT_W-1:0] total_cycle,
  output logic [CNT_W-1:0] num_uncontrol,
  output logic [CNT_W-1:0] num_control,
  output logic [CNT_W-1:0] num_loaduse
);

  logic run;

  // A halted core freezes every counter.
  assign run = !stop;

  event_counter #(.W(CNT_W)) u_total (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .inc   (1'b1),
    .count (total_cycle)
  );

  event_counter #(.W(CNT_W)) u_uncontrol (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .inc   (jmp),
    .count (num_uncontrol)
  );

  event_counter #(.W(CNT_W)) u_control (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .inc   (bjmp),
    .count (num_control)
  );

  event_counter #(.W(CNT_W)) u_loaduse (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .inc   (dependency),
    .count (num_loaduse)
  );

endmodule

// File: tb/tb_cycle_display.sv
// Directed bench for cycle_display: a 32-bit instance and a 4-bit overflow instance.
// Expected overflow values follow CYCLE_DISPLAY_SAT_EN when it is defined.
module tb_cycle_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stop = 1'b0;
  logic        stop4 = 1'b1;
  logic        jmp = 1'b0;
  logic        bjmp = 1'b0;
  logic        dep = 1'b0;

  logic [31:0] tot, unc, ctl, lu;
  logic [3:0]  tot4, unc4, ctl4, lu4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cycle_display #(.CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stop          (stop),
    .jmp           (jmp),
    .bjmp          (bjmp),
    .dependency    (dep),
    .total_cycle   (tot),
    .num_uncontrol (unc),
    .num_control   (ctl),
    .num_loaduse   (lu)
  );

  cycle_display #(.CNT_W(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .stop          (stop4),
    .jmp           (jmp),
    .bjmp          (bjmp),
    .dependency    (dep),
    .total_cycle   (tot4),
    .num_uncontrol (unc4),
    .num_control   (ctl4),
    .num_loaduse   (lu4)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [31:0] t,
                      input logic [31:0] u, input logic [31:0] c,
                      input logic [31:0] l);
    chk({tag, ".total"}, tot, t);
    chk({tag, ".uncontrol"}, unc, u);
    chk({tag, ".control"}, ctl, c);
    chk({tag, ".loaduse"}, lu, l);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    step(1);
    chk4("reset", 0, 0, 0, 0);
    chk("reset.w4_total", {28'd0, tot4}, 0);

    // 10 idle active cycles
    rst = 1'b0;
    step(10);
    chk4("idle10", 10, 0, 0, 0);

    // all three events together: visible right after the edge
    jmp = 1'b1; bjmp = 1'b1; dep = 1'b1;
    step(1);
    chk4("simul", 11, 1, 1, 1);
    dep = 1'b0;
    step(1);
    bjmp = 1'b0;
    step(1);
    jmp = 1'b0;
    step(1);
    chk4("events", 14, 3, 2, 1);

    // reset with stop high and events high overrides everything
    stop = 1'b1; rst = 1'b1; jmp = 1'b1; dep = 1'b1;
    step(1);
    chk4("rst_stop", 0, 0, 0, 0);

    // reach 5 active cycles
    rst = 1'b0; stop = 1'b0; jmp = 1'b0; dep = 1'b0;
    step(5);
    chk4("pre_stop", 5, 0, 0, 0);

    // halt with events high
    stop = 1'b1; jmp = 1'b1; bjmp = 1'b1; dep = 1'b1;
    step(4);
    chk4("stopped", 5, 0, 0, 0);

    // resume: first edge with stop=0 counts, jmp counted once
    stop = 1'b0; bjmp = 1'b0; dep = 1'b0;
    step(1);
    chk4("resume1", 6, 1, 0, 0);
    jmp = 1'b0;
    step(1);
    chk4("resume2", 7, 1, 0, 0);

    // mid-run reset discards counts; next active edge gives 1
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    chk4("after_rst", 1, 0, 0, 0);

    // 4-bit overflow instance
    chk("w4_held", {28'd0, tot4}, 0);
    stop4 = 1'b0;
    step(15);
    chk("w4_15", {28'd0, tot4}, 15);
    step(1);
`ifdef CYCLE_DISPLAY_SAT_EN
    chk("w4_16", {28'd0, tot4}, 15);
`else
    chk("w4_16", {28'd0, tot4}, 0);
`endif
    step(1);
`ifdef CYCLE_DISPLAY_SAT_EN
    chk("w4_17", {28'd0, tot4}, 15);
`else
    chk("w4_17", {28'd0, tot4}, 1);
`endif
    chk("w4_unc", {28'd0, unc4}, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/cycle_display.md
CYCLE_DISPLAY -- requirements
Module: cycle_display

Interface
- REQ-001 Parameter CNT_W, default 32: width of every counter output.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset; synchronous, active-high.
- REQ-004 stop  input  1  processor halted; freezes all counters.
- REQ-005 jmp  input  1  unconditional jump (j/jal) present in EX stage this cycle.
- REQ-006 bjmp  input  1  conditional branch taken in EX stage this cycle.
- REQ-007 dependency  input  1  load-use stall inserted this cycle.
- REQ-008 total_cycle  output  CNT_W  executed (non-halted) clock cycles.
- REQ-009 num_uncontrol  output  CNT_W  unconditional jumps counted.
- REQ-010 num_control  output  CNT_W  taken conditional branches counted.
- REQ-011 num_loaduse  output  CNT_W  load-use stall cycles counted.

Function
- REQ-012 All outputs SHALL be registered, driven directly from internal counter flops; no combinational input-to-output path.
- REQ-013 total_cycle SHALL increment by 1 on each rising edge where rst=0 and stop=0.
- REQ-014 num_uncontrol SHALL increment by 1 on each rising edge where rst=0, stop=0 and jmp=1.
- REQ-015 num_control SHALL increment by 1 on each rising edge where rst=0, stop=0 and bjmp=1.
- REQ-016 num_loaduse SHALL increment by 1 on each rising edge where rst=0, stop=0 and dependency=1.
- REQ-017 Latency: an event sampled at edge N SHALL be visible on the output after edge N (one-cycle latency).
- REQ-018 Simultaneous events: jmp, bjmp and dependency high in the same cycle SHALL each increment their own counter independently, and total_cycle SHALL also increment.
- REQ-019 stop=1 SHALL hold all four counters unchanged, including when event inputs are high.
- REQ-020 Overflow: without the configuration macro, each counter SHALL wrap from all-ones to 0.
- REQ-021 Counters SHALL hold their value indefinitely while stop is high; counting SHALL resume on the first edge with stop=0.

Reset
- REQ-022 rst=1 at a rising edge SHALL clear all four outputs to 0, overriding stop and all event inputs.
- REQ-023 Reset asserted mid-run SHALL discard all accumulated counts; the first edge with rst=0 and stop=0 SHALL set total_cycle to 1.

Configuration
- REQ-024 Macro CYCLE_DISPLAY_SAT_EN defined: each counter SHALL saturate at all-ones and stay there until reset. Macro undefined: wrap per REQ-020. No other behaviour differs.

Structure
- REQ-025 Package cycle_display_pkg SHALL hold the default counter width constant (32) and the all-ones saturation constant.
- REQ-026 One sub-module, event_counter (inputs clk, rst, en, inc; output count), SHALL be instantiated four times. en is driven by !stop. inc is driven by 1, jmp, bjmp and dependency respectively. The sub-module contains the wrap/saturate logic.

Verification
- REQ-027 Stimulus: rst for 1 cycle, then 10 cycles with stop=0 and no events. Required: total_cycle=10 and the other three counters=0.
- REQ-028 Stimulus: jmp=1 for 3 cycles, bjmp=1 for 2 cycles and dependency=1 for 1 cycle, with all three high together in one of those cycles. Required: num_uncontrol=3, num_control=2, num_loaduse=1.
- REQ-029 Stimulus: after reaching total_cycle=5, raise stop for 4 cycles with jmp=1. Required: all counters unchanged, total_cycle=5. Then release stop for 2 cycles. Required: total_cycle=7.
- REQ-030 Stimulus: counts non-zero, then rst=1 for 1 cycle with stop=1. Required: all outputs=0 after that edge.
- REQ-031 Stimulus: CNT_W=4, 17 active cycles. Required without the macro: total_cycle=1. Required with CYCLE_DISPLAY_SAT_EN: total_cycle=15.
